// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for the DIV/DIVU path.
// One quotient bit is resolved per cycle by trial subtraction on operand
// magnitudes; a final FIX cycle applies sign correction and registers HI/LO.
// Build option: define SEQ_DIVIDER_SIGNED_EN to honour Sign (DIV and DIVU);
// without it Sign is ignored and only unsigned division is performed.
//
// Handshake: Start is accepted on a rising edge only while the block is idle
// (Busy=0), and the operands and Sign are captured on that same edge. While
// Busy=1, Start is ignored. Done pulses for exactly one cycle once the
// results are registered. Quotient, Remainder and DivZero then hold until
// the next operation finishes. Busy is already low in the Done cycle, so a
// Start in that cycle begins a new operation back-to-back.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Sign,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;        // working quotient (starts as |dividend|)
  logic [WIDTH-1:0]   rem_q, rem_d;        // partial remainder, always < |divisor|
  logic [WIDTH-1:0]   dvs_q, dvs_d;        // |divisor|
  logic [WIDTH-1:0]   dvd_raw_q, dvd_raw_d;
  logic               dvz_q, dvz_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;

  logic [WIDTH-1:0]   dividend_abs, divisor_abs;
  logic               neg_quo_in, neg_rem_in;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH:0]     shifted, trial;

`ifdef SEQ_DIVIDER_SIGNED_EN
  // Magnitudes and result-sign flags for signed operation; |0x80..0| stays 0x80..0
  // as an unsigned magnitude, which yields the architected overflow result.
  assign dividend_abs = (Sign && Dividend[WIDTH-1]) ? (~Dividend + 1'b1) : Dividend;
  assign divisor_abs  = (Sign && Divisor[WIDTH-1])  ? (~Divisor + 1'b1)  : Divisor;
  assign neg_quo_in   = Sign & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
  assign neg_rem_in   = Sign & Dividend[WIDTH-1];
  assign quo_fix      = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix      = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
`else
  // Unsigned-only build: no magnitude or negate stages, sign flags tied low.
  logic unused_sign;
  assign dividend_abs = Dividend;
  assign divisor_abs  = Divisor;
  assign neg_quo_in   = 1'b0;
  assign neg_rem_in   = 1'b0;
  assign quo_fix      = quo_q;
  assign rem_fix      = rem_q;
  assign unused_sign  = Sign | neg_quo_q | neg_rem_q;
`endif

  // Next-state and datapath: operand capture, shift/subtract step, final fix-up.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    dvd_raw_d   = dvd_raw_q;
    dvz_d       = dvz_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    done_d      = 1'b0;
    div_zero_d  = div_zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    shifted     = {rem_q, quo_q[WIDTH-1]};
    trial       = shifted - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (Start) begin
          dvd_raw_d = Dividend;
          dvz_d     = (Divisor == '0);
          dvs_d     = divisor_abs;
          quo_d     = dividend_abs;
          rem_d     = '0;
          neg_quo_d = neg_quo_in;
          neg_rem_d = neg_rem_in;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end else begin
          // trial[WIDTH]==0 means the shifted remainder covered the divisor
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        if (dvz_q) begin
          quotient_d  = '1;
          remainder_d = dvd_raw_q;
          div_zero_d  = 1'b1;
        end else begin
          quotient_d  = quo_fix;
          remainder_d = rem_fix;
          div_zero_d  = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any operation.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      dvd_raw_q   <= '0;
      dvz_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      dvd_raw_q   <= dvd_raw_d;
      dvz_q       <= dvz_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign DivZero   = div_zero_q;
  assign Quotient  = quotient_q;
  assign Remainder = remainder_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against a
// behavioural division model, with a queue of expected {DivZero,Q,R}.
module tb_seq_divider;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         CLK = 1'b0;
  logic         Reset, Start, Sign;
  logic [W-1:0] Dividend, Divisor;
  logic         Busy, Done, DivZero;
  logic [W-1:0] Quotient, Remainder;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2*W:0] exp_q[$];
  logic [2*W:0] last_exp;

  // clock / reset block
  always #5 CLK = ~CLK;

  seq_divider #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Start     (Start),
    .Sign      (Sign),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .dbg_state (dbg_state)
  );

  // reference model: {divzero, quotient, remainder}
  function automatic logic [2*W:0] model(input logic s, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] q, r;
    logic sg;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sg = s;
`else
    sg = s & 1'b0;
`endif
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    if (!sg) begin
      q = a / b;
      r = a % b;
    end else if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) begin
      q = a;
      r = '0;
    end else begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end
    return {1'b0, q, r};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // driver: present one Start for a single edge, optionally scoreboard it
  task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push);
    Start = 1'b1; Sign = s; Dividend = a; Divisor = b;
    if (push) exp_q.push_back(model(s, a, b));
    tick();
    Start = 1'b0;
    Sign = 1'($urandom_range(0, 1));
    Dividend = $urandom;
    Divisor = $urandom;
    chk("done_pulse_low", W'(Done), '0);
  endtask

  // wait (bounded) for Done, check timing, pop and compare the expected result
  task automatic wait_done(input string tag, input int elapsed);
    int n;
    bit seen, busy_ok;
    logic [2*W:0] e;
    n = elapsed; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && n < LAT + 8) begin
      tick();
      n++;
      if (Done) seen = 1'b1;
      else if (!Busy) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, W'(n), W'(LAT));
    chk({tag, "_busy_high"}, W'(busy_ok), W'(1));
    chk({tag, "_busy_low_at_done"}, W'(Busy), '0);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_queue: observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      chk({tag, "_quotient"}, Quotient, e[2*W-1:W]);
      chk({tag, "_remainder"}, Remainder, e[W-1:0]);
      chk({tag, "_divzero"}, W'(DivZero), W'(e[2*W]));
    end
  endtask

  initial begin
    bit any_done;
    logic s;
    logic [W-1:0] a, b;

    Reset = 1'b1; Start = 1'b0; Sign = 1'b0; Dividend = '0; Divisor = '0;
    repeat (3) tick();
    chk("rst_busy", W'(Busy), '0);
    chk("rst_done", W'(Done), '0);
    chk("rst_divzero", W'(DivZero), '0);
    chk("rst_quotient", Quotient, '0);
    chk("rst_remainder", Remainder, '0);
    Reset = 1'b0;
    tick();

    // unsigned basic
    start_op(1'b0, 32'd100, 32'd7, 1'b1);
    wait_done("udiv", 0);
    chk("udiv_q_const", Quotient, 32'd14);
    chk("udiv_r_const", Remainder, 32'd2);

    // signed pair, second one started in the Done cycle
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("sdiv_neg_dvd", 0);
    start_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done("sdiv_b2b", 0);

    // divide by zero
    repeat (2) tick();
    start_op(1'b1, 32'h1234_5678, 32'd0, 1'b1);
    wait_done("divzero", 0);
    chk("divzero_q_const", Quotient, 32'hFFFF_FFFF);
    chk("divzero_r_const", Remainder, 32'h1234_5678);

    // signed overflow
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("overflow", 0);

    // Start while busy must be ignored
    tick();
    start_op(1'b0, 32'd1000, 32'd3, 1'b1);
    repeat (9) tick();
    Start = 1'b1; Sign = 1'b0; Dividend = 32'd5; Divisor = 32'd1;
    tick();
    Start = 1'b0;
    wait_done("busy_ignore", 10);

    // results hold after Done
    repeat (3) tick();
    chk("hold_quotient", Quotient, last_exp[2*W-1:W]);
    chk("hold_remainder", Remainder, last_exp[W-1:0]);
    chk("hold_done_low", W'(Done), '0);

    // reset in the middle of an operation
    start_op(1'b0, 32'hDEAD_BEEF, 32'd3, 1'b0);
    repeat (14) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midrst_busy", W'(Busy), '0);
    chk("midrst_done", W'(Done), '0);
    chk("midrst_divzero", W'(DivZero), '0);
    chk("midrst_quotient", Quotient, '0);
    chk("midrst_remainder", Remainder, '0);
    any_done = 1'b0;
    repeat (LAT + 6) begin
      tick();
      if (Done) any_done = 1'b1;
    end
    chk("midrst_no_done", W'(any_done), '0);
    start_op(1'b0, 32'hFFFF_FFFF, 32'h10, 1'b1);
    wait_done("after_rst", 0);
    chk("after_rst_q_const", Quotient, 32'h0FFF_FFFF);
    chk("after_rst_r_const", Remainder, 32'hF);

    // random back-to-back operations
    for (int i = 0; i < 10; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case (i % 5)
        0: b = W'($urandom_range(1, 15));
        1: b = -W'($urandom_range(1, 15));
        2: b = $urandom;
        3: b = {16'h0, 16'($urandom)};
        default: b = (i == 4) ? '0 : 32'h1;
      endcase
      start_op(s, a, b, 1'b1);
      wait_done("rand", 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
